sorted_loader: RTL and testbench

- Upstream stage of the binary-search datapath; fills the 32x8 search memory with values kept in ascending order.
- Accepts 8-bit values over a valid/ready stream and inserts each one by insertion sort, shifting one entry per cycle.
- Exposes an asynchronous read port (Addr/Data) to the search datapath, plus status flags.
- Unfilled slots hold 8'hFF, so the full 32-entry array is always sorted when the block is idle.

---
 rtl/sorted_loader_pkg.sv | 15 +
 rtl/sorted_loader.sv | 126 ++++++++++++
 tb/tb_sorted_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_loader_pkg.sv
// Shared constants and state type for the sorted loader and the binary-search datapath.
package sorted_loader_pkg;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    localparam logic [DW-1:0] FILL_VAL = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/sorted_loader.sv
// Insertion-sort loader for the 32x8 search memory, one shift per cycle.
// Optional duplicate discard is enabled by defining SORTED_LOADER_DEDUP_EN.
module sorted_loader
    import sorted_loader_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] Addr,
    output logic [DW-1:0] Data,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          full,
    output logic          dup_drop
);

    state_t        state, state_next;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] v_reg;
    logic [AW:0]   j;
    logic [AW-1:0] jm1_idx;
    logic          shift;
    logic          accept;

    assign full     = (count == (AW+1)'(DEPTH));
    assign in_ready = (state == IDLE) && !full;
    assign busy     = (state == SCAN);
    assign Data     = mem[Addr];

    // j never reaches DEPTH while scanning, so the low AW bits index the array directly.
    assign jm1_idx = AW'(j - (AW+1)'(1));
    assign shift   = (j != '0) && (mem[jm1_idx] > v_reg);

`ifdef SORTED_LOADER_DEDUP_EN
    logic is_dup;
    logic drop;
    logic dup_drop_q;

    always_comb begin
        is_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i < int'(count)) && (mem[i] == in_data)) is_dup = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_dup) begin
                        drop = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!shift) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) dup_drop_q <= 1'b0;
        else     dup_drop_q <= drop;
    end

    assign dup_drop = dup_drop_q;
`else
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (!shift) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dup_drop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_next;
    end

    // Scan walks downward from count, moving larger entries up until the slot for v_reg is found.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= FILL_VAL;
            count <= '0;
            v_reg <= '0;
            j     <= '0;
        end else begin
            if (accept) begin
                v_reg <= in_data;
                j     <= count;
            end
            if (state == SCAN) begin
                if (shift) begin
                    mem[j[AW-1:0]] <= mem[jm1_idx];
                    j              <= j - (AW+1)'(1);
                end else begin
                    mem[j[AW-1:0]] <= v_reg;
                    count          <= count + (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sorted_loader.sv
// Randomized self-checking bench for sorted_loader against a sorted-queue reference model.
module tb_sorted_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] Addr;
    logic [7:0] Data;
    logic [5:0] count;
    logic       busy;
    logic       full;
    logic       dup_drop;

    int total = 0;
    int bad   = 0;
    int model_q[$];

    sorted_loader dut (
        .clk      (clk),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Addr     (Addr),
        .Data     (Data),
        .count    (count),
        .busy     (busy),
        .full     (full),
        .dup_drop (dup_drop)
    );

    always #5 clk = ~clk;

`ifdef SORTED_LOADER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    // Reference: sorted list; k = entries strictly greater than v; latency k+1.
    function automatic void model_push(input int v, output int exp_cycles, output bit exp_drop);
        int pos;
        exp_drop = 1'b0;
        if (DEDUP) begin
            foreach (model_q[i]) if (model_q[i] == v) exp_drop = 1'b1;
        end
        if (exp_drop) begin
            exp_cycles = 0;
            return;
        end
        pos = model_q.size();
        for (int i = model_q.size() - 1; i >= 0; i--) if (model_q[i] > v) pos = i;
        exp_cycles = model_q.size() - pos + 1;
        model_q.insert(pos, v);
    endfunction

    function automatic int model_at(input int i);
        return (i < model_q.size()) ? model_q[i] : 255;
    endfunction

    task automatic do_clr();
        clr      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        model_q.delete();
    endtask

    task automatic push(input logic [7:0] v, output int cycles, output bit dropped,
                        output bit rdy_busy, output bit timeout);
        int n = 0;
        timeout  = 1'b0;
        rdy_busy = 1'b0;
        dropped  = 1'b0;
        cycles   = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            return;
        end
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dropped  = dup_drop;
        while (busy && cycles < 100) begin
            if (in_ready) rdy_busy = 1'b1;
            cycles++;
            @(posedge clk); #1;
        end
        if (busy) timeout = 1'b1;
    endtask

    task automatic test_reset();
        do_clr();
        for (int i = 0; i < 32; i++) begin
            Addr = 5'(i); #1;
            total++;
            if (Data !== 8'hFF) begin
                bad++; $display("FAIL reset_data[%0d]: got %h expected ff", i, Data);
            end
        end
        total++;
        if (count !== 6'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++;
        if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", full); end
    endtask

    task automatic run_inserts(input string name, input int vals[$]);
        int cyc, exp_cyc;
        bit drp, exp_drp, rb, to;
        foreach (vals[n]) begin
            push(8'(vals[n]), cyc, drp, rb, to);
            model_push(vals[n], exp_cyc, exp_drp);
            total++;
            if (to) begin
                bad++; $display("FAIL %s_timeout[%0d]: got timeout expected completion", name, n);
            end
            total++;
            if (cyc !== exp_cyc) begin
                bad++; $display("FAIL %s_latency[%0d] v=%0d: got %0d expected %0d", name, n, vals[n], cyc, exp_cyc);
            end
            total++;
            if (drp !== exp_drp) begin
                bad++; $display("FAIL %s_drop[%0d]: got %b expected %b", name, n, drp, exp_drp);
            end
            total++;
            if (rb !== 1'b0) begin
                bad++; $display("FAIL %s_ready_in_scan[%0d]: got 1 expected 0", name, n);
            end
        end
        for (int i = 0; i < 32; i++) begin
            Addr = 5'(i); #1;
            total++;
            if (Data !== 8'(model_at(i))) begin
                bad++; $display("FAIL %s_data[%0d]: got %0d expected %0d", name, i, Data, model_at(i));
            end
        end
        total++;
        if (count !== 6'(model_q.size())) begin
            bad++; $display("FAIL %s_count: got %0d expected %0d", name, count, model_q.size());
        end
    endtask

    task automatic test_ascending();
        do_clr();
        run_inserts("asc", '{10, 20, 30});
    endtask

    task automatic test_descending();
        do_clr();
        run_inserts("desc", '{30, 20, 10});
    endtask

    task automatic test_fill_full();
        int vals[$];
        int tries = 0;
        int q_model[$];
        do_clr();
        // Pre-pick values so the model reaches 32 distinct-enough entries even with dedup on.
        while (q_model.size() < 32 && tries < 500) begin
            int v = $urandom_range(0, 255);
            bit seen = 1'b0;
            foreach (q_model[i]) if (q_model[i] == v) seen = 1'b1;
            if (!(DEDUP && seen)) q_model.push_back(v);
            vals.push_back(v);
            tries++;
        end
        run_inserts("fill", vals);
        Addr = 5'd0; #1;
        for (int i = 1; i < 32; i++) begin
            logic [7:0] prev;
            Addr = 5'(i - 1); #1; prev = Data;
            Addr = 5'(i); #1;
            total++;
            if (Data < prev) begin
                bad++; $display("FAIL fill_order[%0d]: got %0d after %0d expected non-decreasing", i, Data, prev);
            end
        end
        total++;
        if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b expected 1", full); end
        in_data  = 8'(q_model[0]) ^ 8'h01;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            total++;
            if (in_ready !== 1'b0 || count !== 6'd32 || busy !== 1'b0) begin
                bad++; $display("FAIL full_hold[%0d]: got ready=%b count=%0d busy=%b expected 0/32/0", c, in_ready, count, busy);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_duplicates();
        int pulses = 0;
        do_clr();
        run_inserts("dup", '{5, 5});
        for (int c = 0; c < 3; c++) begin
            if (dup_drop) pulses++;
            @(posedge clk); #1;
        end
        total++;
        if (pulses !== 0) begin
            bad++; $display("FAIL dup_pulse_width: got %0d extra cycles expected 0", pulses);
        end
        total++;
        if (count !== (DEDUP ? 6'd1 : 6'd2)) begin
            bad++; $display("FAIL dup_count: got %0d expected %0d", count, DEDUP ? 1 : 2);
        end
    endtask

    task automatic test_clr_mid_scan();
        do_clr();
        run_inserts("pre", '{10, 20, 30});
        in_data  = 8'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midscan_busy: got %b expected 1", busy); end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_q.delete();
        for (int i = 0; i < 32; i++) begin
            Addr = 5'(i); #1;
            total++;
            if (Data !== 8'hFF) begin
                bad++; $display("FAIL midclr_data[%0d]: got %h expected ff", i, Data);
            end
        end
        total++;
        if (count !== 6'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL midclr_state: got count=%0d busy=%b expected 0/0", count, busy);
        end
    endtask

    task automatic test_random_stream();
        do_clr();
        for (int r = 0; r < 3; r++) begin
            int vals[$];
            int n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) vals.push_back($urandom_range(0, 15));
            run_inserts("rand", vals);
        end
    endtask

    initial begin
        clr      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        Addr     = 5'd0;
        test_reset();
        test_ascending();
        test_descending();
        test_fill_full();
        test_duplicates();
        test_clr_mid_scan();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
